// File: rtl/addr_decode_mr_if.sv
// Bus interface for addr_decode_mr: request/address/write from the CPU side,
// registered decode results (chip select, write enable, offset) and the
// ready/err handshake back.
interface addr_decode_mr_if #(
  parameter int ADDR_W = 32,
  parameter int NREG   = 4
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              WE;
  logic              ready;
  logic              err;
  logic              busy;
  logic [NREG-1:0]   cs;
  logic              iWE;
  logic [ADDR_W-1:0] iAddress;

  modport master (
    output req, addr, WE,
    input  ready, err, busy, cs, iWE, iAddress
  );

  modport slave (
    input  req, addr, WE,
    output ready, err, busy, cs, iWE, iAddress
  );
endinterface

// File: rtl/addr_decode_mr.sv
// Registered multi-region address decoder with wait states and bus error.
// A request is sampled only in IDLE; the winning region (lowest index) gets
// a one-hot chip select held for its wait states plus one response cycle.
// Unmapped addresses and writes to read-only regions answer with err.
// Optional macro ADDR_DEC_MULTIHIT_ERR_EN: overlapping hits return an error
// instead of resolving to the lowest-index region.
module addr_decode_mr #(
  parameter int                    ADDR_W       = 32,
  parameter int                    NREG         = 4,
  parameter logic [NREG*ADDR_W-1:0] REGION_BASE  = {32'h1000_0000, 32'h0000_2000,
                                                    32'h0000_1000, 32'h0000_0000},
  parameter logic [NREG*ADDR_W-1:0] REGION_LIMIT = {32'h1000_00FF, 32'h0000_2FFF,
                                                    32'h0000_1FFF, 32'h0000_0FFF},
  parameter logic [NREG*4-1:0]     WAIT_CYC     = {4'd0, 4'd3, 4'd1, 4'd0},
  parameter logic [NREG-1:0]       REGION_RO    = 4'b0001
) (
  input logic             clk,
  input logic             rst,
  addr_decode_mr_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              ready_reg;
  logic              err_reg;
  logic              busy_reg;
  logic [NREG-1:0]   cs_reg;
  logic              iwe_reg;
  logic [ADDR_W-1:0] iaddr_reg;

  logic [NREG-1:0]   hit;
  logic [NREG-1:0]   sel_onehot;
  logic [ADDR_W-1:0] sel_base;
  logic [3:0]        sel_wait;
  logic              sel_ro;
  logic              any_hit;
  logic              decode_err;

  // Per-region inclusive range compare on the live address.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_hit
      assign hit[gi] = (bus.addr >= REGION_BASE[gi*ADDR_W +: ADDR_W]) &&
                       (bus.addr <= REGION_LIMIT[gi*ADDR_W +: ADDR_W]);
    end
  endgenerate

  assign any_hit    = |hit;
  // Isolate the lowest set hit bit: that region wins on overlap.
  assign sel_onehot = hit & (~hit + NREG'(1));

`ifdef ADDR_DEC_MULTIHIT_ERR_EN
  logic multi_hit;
  assign multi_hit  = (hit & (hit - NREG'(1))) != '0;
  assign decode_err = !any_hit || multi_hit || (sel_ro && bus.WE);
`else
  assign decode_err = !any_hit || (sel_ro && bus.WE);
`endif

  // Fetch base, wait count and RO flag of the winning region; scanning from
  // the top lets the lowest-index hit overwrite the others.
  always_comb begin
    sel_base = '0;
    sel_wait = '0;
    sel_ro   = 1'b0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_base = REGION_BASE[i*ADDR_W +: ADDR_W];
        sel_wait = WAIT_CYC[i*4 +: 4];
        sel_ro   = REGION_RO[i];
      end
    end
  end

  // Access FSM with all bus outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      cs_reg    <= '0;
      iwe_reg   <= 1'b0;
      iaddr_reg <= '0;
    end else begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.req) begin
            busy_reg <= 1'b1;
            if (decode_err) begin
              state_reg <= ERR;
              ready_reg <= 1'b1;
              err_reg   <= 1'b1;
              cs_reg    <= '0;
              iwe_reg   <= 1'b0;
            end else begin
              state_reg <= ACCESS;
              cs_reg    <= sel_onehot;
              iwe_reg   <= bus.WE;
              iaddr_reg <= bus.addr - sel_base;
              cnt_reg   <= sel_wait;
            end
          end
        end
        ACCESS: begin
          if (cnt_reg == 4'd0) begin
            state_reg <= RESP;
            ready_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          cs_reg    <= '0;
          iwe_reg   <= 1'b0;
          iaddr_reg <= '0;
        end
        ERR: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready_reg;
  assign bus.err      = err_reg;
  assign bus.busy     = busy_reg;
  assign bus.cs       = cs_reg;
  assign bus.iWE      = iwe_reg;
  assign bus.iAddress = iaddr_reg;

endmodule

// File: tb/tb_addr_decode_mr.sv
// Testbench for addr_decode_mr: a per-cycle timeline model checked every
// cycle, plus directed transactions with hand-computed expectations.
module tb_addr_decode_mr;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  addr_decode_mr_if #(.ADDR_W(32), .NREG(4)) bus ();
  addr_decode_mr_if #(.ADDR_W(32), .NREG(4)) bus2 ();

  addr_decode_mr u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Second instance with region 0 stretched to overlap region 1.
  addr_decode_mr #(
    .REGION_LIMIT({32'h1000_00FF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_1FFF})
  ) u_ovl (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic        busy;
    logic        ready;
    logic        err;
    logic [3:0]  cs;
    logic        iwe;
    logic [31:0] iaddr;
  } exp_t;

  // Region table for the model, written out as plain numbers.
  logic [31:0] base_t [4] = '{32'h0000_0000, 32'h0000_1000, 32'h0000_2000, 32'h1000_0000};
  logic [31:0] lim_t  [4] = '{32'h0000_0FFF, 32'h0000_1FFF, 32'h0000_2FFF, 32'h1000_00FF};
  int          wait_t [4] = '{0, 1, 3, 0};
  bit          ro_t   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  exp_t cur;
  exp_t q[$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Region index that should serve address a, or -1 for none.
  function automatic int region_of(input logic [31:0] a);
    int r = -1;
    int hits = 0;
    for (int i = 0; i < 4; i++) begin
      if (a >= base_t[i] && a <= lim_t[i]) begin
        hits++;
        if (r < 0) r = i;
      end
    end
`ifdef ADDR_DEC_MULTIHIT_ERR_EN
    if (hits > 1) r = -1;
`endif
    return r;
  endfunction

  // Model: on an accepted request, lay out the whole expected output
  // timeline as a queue of per-cycle values, then replay it.
  initial begin
    cur = '0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        q.delete();
        cur = '0;
      end else if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (cur.busy) begin
        cur = '0;
      end else if (bus.req) begin
        int r;
        exp_t e;
        r = region_of(bus.addr);
        if (r < 0 || (ro_t[r] && bus.WE)) begin
          e = '0; e.busy = 1'b1; e.ready = 1'b1; e.err = 1'b1;
          q.push_back(e);
        end else begin
          for (int k = 0; k <= wait_t[r] + 1; k++) begin
            e = '0;
            e.busy  = 1'b1;
            e.ready = (k == wait_t[r] + 1);
            e.cs    = 4'b0001 << r;
            e.iwe   = bus.WE;
            e.iaddr = bus.addr - base_t[r];
            q.push_back(e);
          end
        end
        cur = q.pop_front();
      end else begin
        cur = '0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en)
        check("cycle", {bus.busy, bus.ready, bus.err, bus.cs, bus.iWE, bus.iAddress}, cur);
    end
  end

  // One request; observes cs/ready/err and checks against literals.
  task automatic txn(input string nm, input logic [31:0] a, input logic we,
                     input logic [3:0] ecs, input logic [31:0] eia, input logic ewe,
                     input logic eerr, input int erdy);
    int cyc = 1;
    int cs_cyc = 0;
    int rdy_at = -1;
    logic [3:0]  cs_seen = '0;
    logic [31:0] ia_seen = '0;
    logic        we_seen = 1'b0;
    logic        err_seen = 1'b0;
    @(negedge clk);
    bus.req = 1'b1; bus.addr = a; bus.WE = we;
    @(negedge clk);
    bus.req = 1'b0; bus.addr = 32'hDEAD_BEEF; bus.WE = ~we;
    while (cyc < 40) begin
      if (bus.cs != '0) begin
        cs_cyc++; cs_seen = bus.cs; ia_seen = bus.iAddress; we_seen = bus.iWE;
      end
      if (bus.ready && rdy_at < 0) begin
        rdy_at = cyc; err_seen = bus.err;
      end
      if (rdy_at >= 0 && !bus.busy) break;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s.ready_cyc", nm), rdy_at, erdy);
    check($sformatf("%s.err", nm), err_seen, eerr);
    check($sformatf("%s.cs", nm), cs_seen, ecs);
    check($sformatf("%s.cs_cycles", nm), cs_cyc, eerr ? 0 : erdy);
    check($sformatf("%s.iaddr", nm), ia_seen, eia);
    check($sformatf("%s.iwe", nm), we_seen, ewe);
    $display("txn %s addr=%h we=%0d ready_cyc=%0d err=%0d cs=%b iaddr=%h",
             nm, a, we, rdy_at, err_seen, cs_seen, ia_seen);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nrdy, r1, r2;
    int ocs_at, ordy;
    logic [3:0] ocs;
    logic oerr;
    logic [31:0] oia;
    bus.req = 1'b0; bus.addr = '0; bus.WE = 1'b0;
    bus2.req = 1'b0; bus2.addr = '0; bus2.WE = 1'b0;

    repeat (2) @(negedge clk);
    check("reset_state", {bus.busy, bus.ready, bus.err, bus.cs, bus.iWE, bus.iAddress}, 40'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    txn("rd_r0",   32'h0000_06F1, 1'b0, 4'b0001, 32'h0000_06F1, 1'b0, 1'b0, 2);
    txn("wr_r2",   32'h0000_2010, 1'b1, 4'b0100, 32'h0000_0010, 1'b1, 1'b0, 5);
    txn("wr_ro",   32'h0000_0500, 1'b1, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1);
    txn("unmap",   32'h0000_3000, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1);
    txn("lim_r1",  32'h0000_1FFF, 1'b0, 4'b0010, 32'h0000_0FFF, 1'b0, 1'b0, 3);
    txn("base_r1", 32'h0000_1000, 1'b1, 4'b0010, 32'h0000_0000, 1'b1, 1'b0, 3);
    txn("lim_r3",  32'h1000_00FF, 1'b0, 4'b1000, 32'h0000_00FF, 1'b0, 1'b0, 2);
    txn("lim_r3+1",32'h1000_0100, 1'b0, 4'b0000, 32'h0000_0000, 1'b0, 1'b1, 1);

    // req held high through RESP: the second access starts only from IDLE.
    nrdy = 0; r1 = -1; r2 = -1;
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 32'h0000_1004; bus.WE = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) bus.req = 1'b0;
      if (bus.ready) begin
        nrdy++;
        if (nrdy == 1) r1 = c; else r2 = c;
      end
    end
    check("held.ready_count", nrdy, 2);
    check("held.first_ready", r1, 3);
    check("held.second_ready", r2, 7);
    $display("txn held_req addr=00001004 readies=%0d at %0d,%0d", nrdy, r1, r2);

    // Reset in the middle of a region 2 access.
    @(negedge clk);
    bus.req = 1'b1; bus.addr = 32'h0000_2010; bus.WE = 1'b1;
    @(negedge clk);
    bus.req = 1'b0;
    @(negedge clk);
    check("mid_rst.busy_before", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("mid_rst.outputs", {bus.busy, bus.ready, bus.err, bus.cs, bus.iWE, bus.iAddress}, 40'd0);
    @(negedge clk);
    rst = 1'b0;
    nrdy = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.ready) nrdy++;
    end
    check("mid_rst.no_ready", nrdy, 0);
    $display("txn mid_reset addr=00002010 readies_after=%0d", nrdy);
    txn("after_rst", 32'h0000_2010, 1'b1, 4'b0100, 32'h0000_0010, 1'b1, 1'b0, 5);

    // Overlapping regions on the second instance.
    ocs = '0; oerr = 1'b0; oia = '0; ocs_at = 0; ordy = -1;
    @(negedge clk);
    bus2.req = 1'b1; bus2.addr = 32'h0000_1800; bus2.WE = 1'b0;
    @(negedge clk);
    bus2.req = 1'b0; bus2.addr = '0;
    for (int c = 1; c <= 10; c++) begin
      if (bus2.cs != '0) begin ocs = bus2.cs; oia = bus2.iAddress; ocs_at++; end
      if (bus2.ready && ordy < 0) begin ordy = c; oerr = bus2.err; end
      @(negedge clk);
    end
`ifdef ADDR_DEC_MULTIHIT_ERR_EN
    check("ovl.err", oerr, 1'b1);
    check("ovl.cs", ocs, 4'b0000);
    check("ovl.ready_cyc", ordy, 1);
`else
    check("ovl.err", oerr, 1'b0);
    check("ovl.cs", ocs, 4'b0001);
    check("ovl.iaddr", oia, 32'h0000_1800);
    check("ovl.cs_cycles", ocs_at, 2);
    check("ovl.ready_cyc", ordy, 2);
`endif
    $display("txn overlap addr=00001800 ready_cyc=%0d err=%0d cs=%b", ordy, oerr, ocs);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/addr_decode_mr.md
Name: addr_decode_mr

Overview:
- Multi-region, registered address decoder with a request/ready handshake for the MIPS data bus.
- Maps a CPU byte address to one of NREG memory-mapped slaves.
- Drives a one-hot chip select, a gated write enable and the region-local offset.
- Inserts per-region wait states; returns a bus error for unmapped addresses and for writes to read-only regions.

Parameters:
- ADDR_W, 32, address width in bits.
- NREG, 4, number of decoded regions (1..8).
- REGION_BASE, {32'h1000_0000,32'h0000_2000,32'h0000_1000,32'h0000_0000}, packed NREG*ADDR_W inclusive base addresses; region i occupies bits [i*ADDR_W +: ADDR_W].
- REGION_LIMIT, {32'h1000_00FF,32'h0000_2FFF,32'h0000_1FFF,32'h0000_0FFF}, packed NREG*ADDR_W inclusive limit addresses.
- WAIT_CYC, {4'd0,4'd3,4'd1,4'd0}, packed NREG*4 wait states per region (0..15).
- REGION_RO, 4'b0001, bit i set means region i is read-only.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  1  master access request, sampled only in IDLE.
- addr  in  ADDR_W  byte address, sampled with req.
- WE  in  1  write request, sampled with req.
- ready  out  1  one-cycle access-complete pulse.
- err  out  1  bus error, coincident with ready.
- busy  out  1  high whenever state != IDLE.
- cs  out  NREG  one-hot slave chip select.
- iWE  out  1  write enable to the selected slave.
- iAddress  out  ADDR_W  addr minus the selected region's base.

Behaviour:
- One clock (clk); reset (rst) is asynchronous and active-high.
- Reset (async, at any time, including mid-access) forces state=IDLE, cnt=0 and ready=err=busy=iWE=0, cs=0, iAddress=0 immediately. The access in flight is dropped with no ready.
- All outputs are registered; there is no combinational path from addr, req or WE to any output.
- Hit test: hit[i] = (addr >= BASE[i]) && (addr <= LIMIT[i]), unsigned, both bounds inclusive.
- Priority: when several hits occur, the lowest index wins.
- FSM states: IDLE, ACCESS, RESP, ERR.
- IDLE, req=1 at edge E0:
  - if no hit, or (winning region RO and WE=1): go to ERR; cs=0, iWE=0.
  - otherwise: go to ACCESS; cs=onehot(i); iWE=WE; iAddress=addr-BASE[i] (ADDR_W-bit subtract, no wrap possible); cnt=WAIT_CYC[i].
- ACCESS: if cnt==0, go to RESP; else cnt decrements. cs, iWE and iAddress stay held.
- RESP: ready=1 for exactly one cycle with cs, iWE and iAddress still held. Next edge returns to IDLE and clears cs, iWE and iAddress.
- ERR: ready=1 and err=1 for one cycle, cs=0, iWE=0. Next edge returns to IDLE.
- Timing:
  - cs is asserted for WAIT+2 cycles.
  - ready is high in the cycle after edge E0+WAIT+1.
  - Error response: ready is high in the cycle after E0.
- req while busy is ignored, not queued. The minimum request spacing is WAIT+3 cycles on a hit and 2 cycles on an error.
- addr and WE may change after E0; the latched values are used.
- Boundaries:
  - addr==BASE[i] gives iAddress=0.
  - addr==LIMIT[i] hits region i.
  - addr==LIMIT[i]+1 falls to the next match or to error.

Optional Feature:
- Macro: ADDR_DEC_MULTIHIT_ERR_EN.
- Defined: more than one hit bit set at E0 takes the ERR path (err=1, cs never asserted), the same as an unmapped address.
- Undefined: lowest-index priority as described above; overlap is silent.

Test Plan:
- Read, region 0: req, addr=32'h0000_06F1, WE=0 -> cs=4'b0001 for 2 cycles, iAddress=32'h0000_06F1, iWE=0, ready one cycle after E0+1, err=0.
- Write, region 2 (3 waits): addr=32'h0000_2010, WE=1 -> cs=4'b0100 for 5 cycles, iAddress=32'h10, iWE=1, ready after E0+4.
- Error path:
  - Write to RO region 0, addr=32'h0000_0500, WE=1 -> ready=err=1 in cycle after E0, cs stays 0.
  - Unmapped addr=32'h0000_3000 -> same error response.
- Bounds and ignored request:
  - addr=32'h0000_1FFF -> cs=4'b0010, iAddress=32'h0FFF.
  - addr=32'h1000_0100 -> err.
  - req held high through RESP -> second access starts only after return to IDLE.
- Reset mid-access: rst pulsed during region 2 ACCESS -> cs, iWE, busy, ready drop immediately; no ready; next req decodes normally.
- Overlap (override LIMIT[0]=32'h0000_1FFF), addr=32'h0000_1800 -> cs=4'b0001 without macro; err=1 with ADDR_DEC_MULTIHIT_ERR_EN.
